// File: rtl/toysram_scan_ctrl_if.sv
// Scan sequencer bus: user-side control/data plus the macro-side scan pins.
// The slave modport is the sequencer; the master modport is whatever drives it.
interface toysram_scan_ctrl_if #(
    parameter int SCAN_LEN = 128,
    parameter int CHANNELS = 1
);
    logic                         start;
    logic                         abort;
    logic [CHANNELS*SCAN_LEN-1:0] load_data;
    logic [CHANNELS*SCAN_LEN-1:0] exp_data;
    logic [CHANNELS*SCAN_LEN-1:0] exp_mask;
    logic [CHANNELS*SCAN_LEN-1:0] cap_data;
    logic                         busy;
    logic                         done;
    logic                         error;
    logic                         te;
    logic                         scan_clk;
    logic [CHANNELS-1:0]          scan_in;
    logic [CHANNELS-1:0]          scan_out;

    modport master (
        output start, abort, load_data, exp_data, exp_mask, scan_out,
        input  cap_data, busy, done, error, te, scan_clk, scan_in
    );

    modport slave (
        input  start, abort, load_data, exp_data, exp_mask, scan_out,
        output cap_data, busy, done, error, te, scan_clk, scan_in
    );
endinterface

// File: rtl/toysram_scan_ctrl.sv
// Hardware scan sequencer for the toy SRAM macros: shift a load vector through
// CHANNELS chains and capture the return. Compare logic exists only with TOYSRAM_SCAN_CMP_EN.
module toysram_scan_ctrl #(
    parameter int SCAN_LEN = 128,
    parameter int CHANNELS = 1,
    parameter int DIV      = 4
) (
    input  logic               clock,
    input  logic               resetb,
    toysram_scan_ctrl_if.slave bus
);
    localparam int W    = CHANNELS * SCAN_LEN;
    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BC_W = $clog2(SCAN_LEN);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(DIV - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(SCAN_LEN - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, FIN} state_t;

    state_t          state, state_nxt;
    logic [PH_W-1:0] phase;
    logic [BC_W-1:0] bit_cnt;
    logic [W-1:0]    load_sr;
    logic [W-1:0]    cap_sr;
    logic            busy_q, done_q, error_q, te_q, sclk_q;
    logic            accept, halt, phase_end, shift_sample, shift_adv;

    // Shift every channel left by one, filling each channel's LSB from lsb[c].
    function automatic logic [W-1:0] chain_shift(input logic [W-1:0] v,
                                                 input logic [CHANNELS-1:0] lsb);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            r[c*SCAN_LEN +: SCAN_LEN] = {v[c*SCAN_LEN +: SCAN_LEN-1], lsb[c]};
        end
        return r;
    endfunction

    assign accept       = (state == IDLE) && bus.start && !bus.abort;
    assign halt         = (state != IDLE) && bus.abort;
    assign phase_end    = (phase == PH_LAST);
    assign shift_sample = (state == SHIFT_LO) && phase_end && !halt;
    assign shift_adv    = (state == SHIFT_HI) && phase_end && !halt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = SETUP;
            SETUP:    if (phase_end) state_nxt = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_nxt = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_nxt = (bit_cnt == BIT_LAST) ? HOLD : SHIFT_LO;
            HOLD:     if (phase_end) state_nxt = FIN;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (halt) state_nxt = IDLE;
    end

    // Pin-facing controls are registered from the next state so they never glitch.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            te_q    <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            phase  <= (state == IDLE || state_nxt != state) ? '0 : phase + PH_W'(1);
            busy_q <= (state_nxt != IDLE);
            te_q   <= (state_nxt != IDLE);
            sclk_q <= (state_nxt == SHIFT_HI);
            done_q <= (state == FIN) && !halt;
            if (accept) begin
                bit_cnt <= '0;
            end else if (shift_adv && bit_cnt != BIT_LAST) begin
                bit_cnt <= bit_cnt + BC_W'(1);
            end
        end
    end

    // The load register is cleared on abort so scan_in rests low in IDLE.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            load_sr <= '0;
            cap_sr  <= '0;
        end else begin
            if (accept) begin
                load_sr <= bus.load_data;
            end else if (halt) begin
                load_sr <= '0;
            end else if (shift_adv) begin
                load_sr <= chain_shift(load_sr, '0);
            end
            if (shift_sample) begin
                cap_sr <= chain_shift(cap_sr, bus.scan_out);
            end
        end
    end

`ifdef TOYSRAM_SCAN_CMP_EN
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (state == FIN && !halt) begin
            error_q <= |((cap_sr ^ bus.exp_data) & bus.exp_mask);
        end
    end
`else
    assign error_q = 1'b0;
`endif

    always_comb begin
        bus.scan_in = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bus.scan_in[c] = load_sr[c*SCAN_LEN + SCAN_LEN - 1];
        end
    end

    assign bus.cap_data = cap_sr;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.te       = te_q;
    assign bus.scan_clk = sclk_q;
endmodule

// File: tb/tb_toysram_scan_ctrl.sv
// Bench for toysram_scan_ctrl: ideal flop chains on scan_clk, directed and random
// operations checked against a chain-content reference model.
module tb_toysram_scan_ctrl;
    localparam int SCAN_LEN = 8;
    localparam int CHANNELS = 2;
    localparam int DIV      = 2;
    localparam int W        = SCAN_LEN * CHANNELS;
    localparam int LAT      = DIV + 2*DIV*SCAN_LEN + DIV + 1;

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    always #5 clock = ~clock;

    toysram_scan_ctrl_if #(.SCAN_LEN(SCAN_LEN), .CHANNELS(CHANNELS)) sif ();

    toysram_scan_ctrl #(.SCAN_LEN(SCAN_LEN), .CHANNELS(CHANNELS), .DIV(DIV)) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (sif.slave)
    );

    // Ideal SCAN_LEN-flop chain per channel, clocked by scan_clk.
    logic [W-1:0] chain = '0;
    always @(posedge sif.scan_clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            chain[c*SCAN_LEN +: SCAN_LEN] <= {chain[c*SCAN_LEN +: SCAN_LEN-1], sif.scan_in[c]};
        end
    end
    always_comb begin
        sif.scan_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sif.scan_out[c] = chain[c*SCAN_LEN + SCAN_LEN - 1];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the chains hold, what cap_data and error should show.
    logic [W-1:0] chain_m = '0;
    logic [W-1:0] cap_m   = '0;
    logic         err_m   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic want_error(input logic [W-1:0] cap, input logic [W-1:0] ex,
                                        input logic [W-1:0] mk);
`ifdef TOYSRAM_SCAN_CMP_EN
        return |((cap ^ ex) & mk);
`else
        return 1'b0;
`endif
    endfunction

    // Scan bits completed when the run stops right after edge e (start edge = 0).
    function automatic int bits_done(input int e);
        int n = 0;
        for (int j = 0; j < SCAN_LEN; j++) begin
            if (2*DIV + 2*DIV*j <= e) n++;
        end
        return n;
    endfunction

    // Per channel: hi shifted left by n with the top n bits of lo appended.
    function automatic logic [W-1:0] mix(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                         input int n);
        logic [W-1:0]        r;
        logic [SCAN_LEN-1:0] a, b;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            a = hi[c*SCAN_LEN +: SCAN_LEN];
            b = lo[c*SCAN_LEN +: SCAN_LEN];
            r[c*SCAN_LEN +: SCAN_LEN] = (a << n) | (b >> (SCAN_LEN - n));
        end
        return r;
    endfunction

    task automatic run_op(input logic [W-1:0] ld, input logic [W-1:0] ex,
                          input logic [W-1:0] mk, input bit extra_start);
        logic [W-1:0] want_cap;
        logic         want_err;
        logic         prev_sclk;
        int           lat, hi, rises, te_low;
        want_cap = chain_m;
        want_err = want_error(want_cap, ex, mk);
        sif.load_data = ld;
        sif.exp_data  = ex;
        sif.exp_mask  = mk;
        sif.start     = 1'b1;
        @(negedge clock);
        sif.start = 1'b0;
        chk("busy_after_start", sif.busy, 1);
        chk("error_cleared_by_start", sif.error, 0);
        lat = 0; hi = 0; rises = 0; te_low = 0; prev_sclk = 1'b0;
        for (int k = 1; k <= LAT + 8; k++) begin
            sif.start = extra_start && (k == 5);
            @(negedge clock);
            if (sif.scan_clk) hi++;
            if (sif.scan_clk && !prev_sclk) rises++;
            prev_sclk = sif.scan_clk;
            if (k < LAT && !sif.te) te_low++;
            if (sif.done) begin
                lat = k;
                break;
            end
        end
        sif.start = 1'b0;
        chk("done_latency", lat, LAT);
        chk("scan_clk_high_cycles", hi, SCAN_LEN*DIV);
        chk("scan_clk_pulses", rises, SCAN_LEN);
        chk("te_low_while_busy", te_low, 0);
        chk("cap_data", sif.cap_data, want_cap);
        chk("error", sif.error, want_err);
        chk("busy_at_done", sif.busy, 0);
        chk("te_at_done", sif.te, 0);
        @(negedge clock);
        chk("done_one_cycle", sif.done, 0);
        chk("cap_data_hold", sif.cap_data, want_cap);
        chain_m = ld;
        cap_m   = want_cap;
        err_m   = want_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ld, ex, mk;
        logic         saw_done;
        sif.start     = 1'b0;
        sif.abort     = 1'b0;
        sif.load_data = '0;
        sif.exp_data  = '0;
        sif.exp_mask  = '0;

        repeat (3) @(negedge clock);
        chk("reset_busy", sif.busy, 0);
        chk("reset_te", sif.te, 0);
        chk("reset_cap", sif.cap_data, 0);
        resetb = 1'b1;
        @(negedge clock);
        chk("idle_busy", sif.busy, 0);

        // Loopback: the second run returns the first run's load.
        run_op({8'h5A, 8'hA5}, W'($urandom), W'($urandom), 1'b0);
        run_op({8'hC3, 8'h3C}, {8'h5A, 8'hA5}, '1, 1'b1);
        run_op({8'h5A, 8'hA5}, '0, '0, 1'b0);
        // Compare cases on a {0x5A,0xA5} capture.
        run_op({8'h5A, 8'hA5}, {8'h5A, 8'hA5}, 16'hFFFF, 1'b0);
        run_op({8'h5A, 8'hA5}, {8'h5A, 8'hA4}, 16'hFFFF, 1'b0);
        repeat (4) @(negedge clock);
        chk("error_sticky", sif.error, err_m);
        run_op({8'h5A, 8'hA5}, {8'h5A, 8'hA4}, 16'hFFFE, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ld = W'($urandom);
            mk = W'($urandom);
            ex = ($urandom_range(0, 1) == 1) ? chain_m : W'($urandom);
            run_op(ld, ex, mk, 1'b0);
        end

        // Abort sampled on edge 10 after the start edge.
        ld = W'($urandom);
        sif.load_data = ld;
        sif.start = 1'b1;
        @(negedge clock);
        sif.start = 1'b0;
        repeat (9) @(negedge clock);
        sif.abort = 1'b1;
        @(negedge clock);
        sif.abort = 1'b0;
        chk("abort_busy", sif.busy, 0);
        chk("abort_te", sif.te, 0);
        chk("abort_scan_clk", sif.scan_clk, 0);
        cap_m   = mix(cap_m, chain_m, bits_done(9));
        chain_m = mix(chain_m, ld, bits_done(9));
        err_m   = 1'b0;
        saw_done = 1'b0;
        repeat (LAT) begin
            @(negedge clock);
            if (sif.done || sif.busy) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_cap_partial", sif.cap_data, cap_m);
        chk("abort_error", sif.error, err_m);

        // Abort alone in IDLE, then start+abort together.
        sif.abort = 1'b1;
        @(negedge clock);
        chk("idle_abort_busy", sif.busy, 0);
        sif.start = 1'b1;
        @(negedge clock);
        sif.start = 1'b0;
        sif.abort = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (sif.busy || sif.done || sif.te) saw_done = 1'b1;
        end
        chk("start_abort_no_op", saw_done, 0);
        chk("start_abort_cap", sif.cap_data, cap_m);

        run_op(W'($urandom), chain_m, W'($urandom), 1'b0);

        // Asynchronous reset in the middle of an operation.
        ld = W'($urandom);
        sif.load_data = ld;
        sif.start = 1'b1;
        @(negedge clock);
        sif.start = 1'b0;
        repeat (20) @(negedge clock);
        #2;
        resetb = 1'b0;
        #1;
        chk("midreset_busy", sif.busy, 0);
        chk("midreset_done", sif.done, 0);
        chk("midreset_error", sif.error, 0);
        chk("midreset_te", sif.te, 0);
        chk("midreset_scan_clk", sif.scan_clk, 0);
        chk("midreset_scan_in", sif.scan_in, 0);
        chk("midreset_cap", sif.cap_data, 0);
        chain_m = mix(chain_m, ld, bits_done(20));
        cap_m   = '0;
        err_m   = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (sif.busy || sif.done) saw_done = 1'b1;
        end
        chk("post_reset_idle", saw_done, 0);

        run_op(W'($urandom), W'($urandom), W'($urandom), 1'b0);
        run_op(W'($urandom), chain_m, '1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
